sm_issue_budget_ctrl: RTL

- Parametrised successor to the single-SM voltage-to-issue-width controller.
- Supports NUM_SM streaming multiprocessors. Each SM's supply-voltage code sets its instruction-issue budget for a fixed window of WINDOW cycles.
- Per cycle, each SM gets an issue allowance; the reported issue count is debited from that SM's budget.
- Sits between the voltage monitors and the SM issue schedulers.

---
 rtl/sm_issue_budget_pkg.sv | 23 ++
 rtl/sm_budget_lane.sv | 71 +++++++
 rtl/sm_issue_budget_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/sm_issue_budget_pkg.sv
// Shared types and arithmetic helpers for the SM issue-budget controller.
// Pure definitions: no latency and no flow control.
package sm_issue_budget_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Higher supply code means a larger penalty; the penalty is clamped so the budget floors at zero.
  function automatic int calc_budget(input int volt, input int div, input int bmax);
    int pen;
    pen = volt / div;
    if (pen > bmax) pen = bmax;
    return bmax - pen;
  endfunction

  function automatic int sat_sub(input int a, input int b);
    return (b > a) ? 0 : a - b;
  endfunction

endpackage

// File: rtl/sm_budget_lane.sv
// One SM lane: remaining budget, allowance, debit, window reload and sticky overissue flag.
// Allowance is combinational from registered budget; no backpressure, over-issue is only flagged.
module sm_budget_lane
  import sm_issue_budget_pkg::*;
#(
  parameter int VOLT_W     = 8,
  parameter int DIV        = 10,
  parameter int BUDGET_MAX = 20,
  parameter int ISSUE_W    = 3,
  parameter int BUD_W      = 5,
  parameter int ISSUE_MAX  = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               reload,
  input  logic               run,
  input  logic               clear_err,
  input  logic [VOLT_W-1:0]  voltage,
  input  logic [ISSUE_W-1:0] issued,
  output logic [ISSUE_W-1:0] allow,
  output logic [BUD_W-1:0]   remaining,
  output logic               overissue
);

  logic [BUD_W-1:0] fresh;
  logic [BUD_W-1:0] reload_val;
  logic [BUD_W-1:0] debit_val;

  assign fresh     = BUD_W'(calc_budget(int'(voltage), DIV, BUDGET_MAX));
  assign debit_val = BUD_W'(sat_sub(int'(remaining), int'(issued)));

`ifdef BUDGET_CARRY_EN
  logic [BUD_W:0] carry_sum;
  assign carry_sum  = {1'b0, fresh} + {1'b0, remaining};
  // Leftover is taken before this cycle's debit, which is discarded on reload.
  assign reload_val = (int'(carry_sum) > BUDGET_MAX) ? BUD_W'(BUDGET_MAX) : carry_sum[BUD_W-1:0];
`else
  assign reload_val = fresh;
`endif

  always_comb begin
    allow = '0;
    if (run) begin
      allow = (int'(remaining) > ISSUE_MAX) ? ISSUE_W'(ISSUE_MAX) : ISSUE_W'(remaining);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= fresh;
    end else if (reload) begin
      remaining <= reload_val;
    end else if (run) begin
      remaining <= debit_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overissue <= 1'b0;
    end else if (clear_err) begin
      overissue <= 1'b0;
    end else if (run && (issued > allow)) begin
      overissue <= 1'b1;
    end
  end

endmodule

// File: rtl/sm_issue_budget_ctrl.sv
// Per-SM issue budget controller: voltage sets a per-window budget, issues debit it (BUDGET_CARRY_EN: carry leftover).
// One LOAD cycle after enable, then back-to-back windows; no backpressure, over-issue raises a sticky flag.
module sm_issue_budget_ctrl
  import sm_issue_budget_pkg::*;
#(
  parameter int NUM_SM     = 4,
  parameter int VOLT_W     = 8,
  parameter int DIV        = 10,
  parameter int BUDGET_MAX = 20,
  parameter int WINDOW     = 10,
  parameter int ISSUE_W    = 3,
  localparam int BUD_W     = $clog2(BUDGET_MAX + 1),
  localparam int ISSUE_MAX = 2**ISSUE_W - 1
) (
  input  logic                      clk_controller,
  input  logic                      rst_n_controller,
  input  logic                      ctrl_en,
  input  logic [NUM_SM*VOLT_W-1:0]  sm_voltage,
  input  logic [NUM_SM*ISSUE_W-1:0] sm_issued,
  input  logic                      clear_err,
  output logic [NUM_SM*ISSUE_W-1:0] sm_allow,
  output logic [NUM_SM*BUD_W-1:0]   sm_remaining,
  output logic                      window_done,
  output logic [NUM_SM-1:0]         overissue
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [1:0]       rst_sync;
  logic             rst_n;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             load;
  logic             reload;

  // Assertion is immediate; release is retimed to the clock.
  always_ff @(posedge clk_controller or negedge rst_n_controller) begin
    if (!rst_n_controller) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk_controller or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_en) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (!ctrl_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run         = (state == RUN);
    load        = (state == LOAD);
    window_done = run && (cnt == '0);
    reload      = window_done && ctrl_en;
  end

  always_ff @(posedge clk_controller or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case (state)
        LOAD:    cnt <= CNT_W'(WINDOW - 1);
        RUN: begin
          if (!ctrl_en)        cnt <= '0;
          else if (cnt == '0)  cnt <= CNT_W'(WINDOW - 1);
          else                 cnt <= cnt - 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SM; i++) begin : g_lane
    sm_budget_lane #(
      .VOLT_W     (VOLT_W),
      .DIV        (DIV),
      .BUDGET_MAX (BUDGET_MAX),
      .ISSUE_W    (ISSUE_W),
      .BUD_W      (BUD_W),
      .ISSUE_MAX  (ISSUE_MAX)
    ) u_lane (
      .clk       (clk_controller),
      .rst_n     (rst_n),
      .load      (load),
      .reload    (reload),
      .run       (run),
      .clear_err (clear_err),
      .voltage   (sm_voltage[i*VOLT_W +: VOLT_W]),
      .issued    (sm_issued[i*ISSUE_W +: ISSUE_W]),
      .allow     (sm_allow[i*ISSUE_W +: ISSUE_W]),
      .remaining (sm_remaining[i*BUD_W +: BUD_W]),
      .overissue (overissue[i])
    );
  end

endmodule
